// File: rtl/seg_pkg.sv
// Segment glyphs, BCD-to-segment decode and converter state enum for the scan mux.
// Latency: none, declarations only.
// Backpressure: none.
package seg_pkg;

  // Active-low glyphs, bit order g..a.
  localparam logic [6:0] SEG_D0    = 7'b1000000;
  localparam logic [6:0] SEG_D1    = 7'b1111001;
  localparam logic [6:0] SEG_D2    = 7'b0100100;
  localparam logic [6:0] SEG_D3    = 7'b0110000;
  localparam logic [6:0] SEG_D4    = 7'b0011001;
  localparam logic [6:0] SEG_D5    = 7'b0010010;
  localparam logic [6:0] SEG_D6    = 7'b0000010;
  localparam logic [6:0] SEG_D7    = 7'b1111000;
  localparam logic [6:0] SEG_D8    = 7'b0000000;
  localparam logic [6:0] SEG_D9    = 7'b0010000;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_DONE
  } conv_state_t;

  // Non-decimal codes never reach the display; they map to blank.
  function automatic logic [6:0] bcd_to_seg(input logic [3:0] d);
    case (d)
      4'd0:    bcd_to_seg = SEG_D0;
      4'd1:    bcd_to_seg = SEG_D1;
      4'd2:    bcd_to_seg = SEG_D2;
      4'd3:    bcd_to_seg = SEG_D3;
      4'd4:    bcd_to_seg = SEG_D4;
      4'd5:    bcd_to_seg = SEG_D5;
      4'd6:    bcd_to_seg = SEG_D6;
      4'd7:    bcd_to_seg = SEG_D7;
      4'd8:    bcd_to_seg = SEG_D8;
      4'd9:    bcd_to_seg = SEG_D9;
      default: bcd_to_seg = SEG_BLANK;
    endcase
  endfunction

  // Decimal digits needed for the largest w-bit value: floor(w*log10(2))+1.
  function automatic int bcd_digits(input int w);
    return (w * 30103) / 100000 + 1;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter, one add-3/shift step per clock.
// Latency: start edge -> VAL_W shift edges -> one DONE cycle (done_o high, bcd_o valid).
// Backpressure: start_i is only accepted while busy_o is low; no stall once running.
module bin2bcd_seq
  import seg_pkg::*;
#(
  parameter int VAL_W  = 16,
  parameter int DIGITS = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic [VAL_W-1:0]      bin_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [4*DIGITS-1:0]   bcd_o
);

  localparam int SR_W  = 4 * DIGITS + VAL_W;
  localparam int CNT_W = $clog2(VAL_W + 1);

  conv_state_t      state_q;
  logic [SR_W-1:0]  sr_q;
  logic [SR_W-1:0]  adj_d;
  logic [CNT_W-1:0] cnt_q;
  logic             done_q;

  // Add 3 to every BCD digit that is 5 or more, ahead of the shift.
  always_comb begin
    adj_d = sr_q;
    for (int d = 0; d < DIGITS; d++) begin
      if (sr_q[VAL_W+4*d +: 4] >= 4'd5) begin
        adj_d[VAL_W+4*d +: 4] = sr_q[VAL_W+4*d +: 4] + 4'd3;
      end
    end
  end

  // Converter FSM: load on start, VAL_W correction/shift steps, one DONE cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (start_i) begin
            sr_q    <= {{(4*DIGITS){1'b0}}, bin_i};
            cnt_q   <= '0;
            state_q <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          sr_q  <= {adj_d[SR_W-2:0], 1'b0};
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CNT_W'(VAL_W - 1)) begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy_o = (state_q != ST_IDLE);
  assign done_o = done_q;
  assign bcd_o  = sr_q[SR_W-1:VAL_W];

endmodule

// File: rtl/seg_scan_mux.sv
// Two-channel multiplexed 7-segment driver: binary values converted to BCD and scanned out.
// Latency: upd edge to display-register write is VAL_W+2 edges when idle; seg/an are registered.
// Backpressure: none; repeat updates coalesce into a per-channel shadow. Blink via SEG_SCAN_BLINK_EN.
module seg_scan_mux
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS = 8,
  parameter int VAL_W      = 16,
  parameter int SCAN_DIV   = 10000,
  parameter int GAP        = 100
`ifdef SEG_SCAN_BLINK_EN
  , parameter int BLINK_DIV = 50_000_000
`endif
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [VAL_W-1:0]      val_a,
  input  logic [VAL_W-1:0]      val_b,
  input  logic                  upd_a,
  input  logic                  upd_b,
  input  logic [NUM_DIGITS-1:0] dp_mask,
  input  logic                  lzb,
`ifdef SEG_SCAN_BLINK_EN
  input  logic [NUM_DIGITS-1:0] blink_mask,
`endif
  output logic                  busy,
  output logic [7:0]            seg,
  output logic [NUM_DIGITS-1:0] an
);

  localparam int HALF     = NUM_DIGITS / 2;
  localparam int CONV_DIG = (bcd_digits(VAL_W) > HALF) ? bcd_digits(VAL_W) : HALF;
  localparam int DIG_W    = $clog2(NUM_DIGITS);
  localparam int SLOT_W   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [VAL_W-1:0]      shadow_a_q, shadow_b_q;
  logic                  pend_a_q, pend_b_q;
  logic                  last_b_q, cur_b_q;
  logic                  sel_b, conv_start;
  logic [VAL_W-1:0]      conv_bin;
  logic                  conv_busy, conv_done, conv_ovf;
  logic [4*CONV_DIG-1:0] conv_bcd;

  logic [4*HALF-1:0]     disp_a_q, disp_b_q;
  logic                  ovf_a_q, ovf_b_q;

  logic [SLOT_W-1:0]     slot_q, slot_d;
  logic [DIG_W-1:0]      dig_q, dig_d;
  logic [7:0]            seg_q, seg_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;

  // Round-robin pick: when both channels wait, the one not served last goes first.
  always_comb begin
    sel_b      = pend_b_q && (!pend_a_q || !last_b_q);
    conv_start = (pend_a_q || pend_b_q) && !conv_busy;
    conv_bin   = sel_b ? shadow_b_q : shadow_a_q;
  end

  // Capture update requests; a new pulse always wins over the clear caused by a start.
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_a_q <= '0;
      shadow_b_q <= '0;
      pend_a_q   <= 1'b0;
      pend_b_q   <= 1'b0;
      last_b_q   <= 1'b1;
      cur_b_q    <= 1'b0;
    end else begin
      if (upd_a) shadow_a_q <= val_a;
      if (upd_b) shadow_b_q <= val_b;
      if (upd_a)                      pend_a_q <= 1'b1;
      else if (conv_start && !sel_b)  pend_a_q <= 1'b0;
      if (upd_b)                      pend_b_q <= 1'b1;
      else if (conv_start && sel_b)   pend_b_q <= 1'b0;
      if (conv_start) begin
        last_b_q <= sel_b;
        cur_b_q  <= sel_b;
      end
    end
  end

  bin2bcd_seq #(
    .VAL_W  (VAL_W),
    .DIGITS (CONV_DIG)
  ) u_conv (
    .clk     (clk),
    .rst     (rst),
    .start_i (conv_start),
    .bin_i   (conv_bin),
    .busy_o  (conv_busy),
    .done_o  (conv_done),
    .bcd_o   (conv_bcd)
  );

  // Any non-zero digit above the displayed half means the value does not fit.
  if (CONV_DIG > HALF) begin : g_ovf
    assign conv_ovf = |conv_bcd[4*CONV_DIG-1:4*HALF];
  end else begin : g_no_ovf
    assign conv_ovf = 1'b0;
  end

  // Display registers change only on the converter's DONE cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      disp_a_q <= '0;
      disp_b_q <= '0;
      ovf_a_q  <= 1'b0;
      ovf_b_q  <= 1'b0;
    end else if (conv_done) begin
      if (cur_b_q) begin
        disp_b_q <= conv_bcd[4*HALF-1:0];
        ovf_b_q  <= conv_ovf;
      end else begin
        disp_a_q <= conv_bcd[4*HALF-1:0];
        ovf_a_q  <= conv_ovf;
      end
    end
  end

`ifdef SEG_SCAN_BLINK_EN
  localparam int BLK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  logic [BLK_W-1:0] blk_cnt_q;
  logic             blink_phase_q, blink_phase_d;

  always_comb blink_phase_d = (blk_cnt_q == BLK_W'(BLINK_DIV - 1)) ? ~blink_phase_q : blink_phase_q;

  // Free-running blink phase; phase 1 is the off half.
  always_ff @(posedge clk) begin
    if (rst) begin
      blk_cnt_q     <= '0;
      blink_phase_q <= 1'b0;
    end else begin
      blink_phase_q <= blink_phase_d;
      if (blk_cnt_q == BLK_W'(BLINK_DIV - 1)) blk_cnt_q <= '0;
      else                                    blk_cnt_q <= blk_cnt_q + 1'b1;
    end
  end
`endif

  // Next slot position; outputs are derived from it so they line up with the counter.
  always_comb begin
    slot_d = slot_q + 1'b1;
    dig_d  = dig_q;
    if (slot_q == SLOT_W'(SCAN_DIV - 1)) begin
      slot_d = '0;
      dig_d  = (dig_q == DIG_W'(NUM_DIGITS - 1)) ? '0 : dig_q + 1'b1;
    end
  end

  logic              is_b, ovf_sel, upper_zero;
  logic [DIG_W-1:0]  pos;
  int                pos_i;
  logic [4*HALF-1:0] disp_sel;
  logic [3:0]        nib;
  logic [6:0]        glyph;

  // Glyph and anode pattern for the digit in the upcoming slot.
  always_comb begin
    is_b       = (dig_d >= DIG_W'(HALF));
    pos        = is_b ? dig_d - DIG_W'(HALF) : dig_d;
    pos_i      = int'(pos);
    disp_sel   = is_b ? disp_b_q : disp_a_q;
    ovf_sel    = is_b ? ovf_b_q : ovf_a_q;
    nib        = disp_sel[4*pos_i +: 4];
    upper_zero = ((disp_sel >> (4 * pos_i)) == '0);
    if (ovf_sel)                                 glyph = SEG_DASH;
    else if (lzb && (pos != '0) && upper_zero)   glyph = SEG_BLANK;
    else                                         glyph = bcd_to_seg(nib);
    seg_d = {~dp_mask[dig_d], glyph};
`ifdef SEG_SCAN_BLINK_EN
    if (blink_phase_d && blink_mask[dig_d]) seg_d = 8'hFF;
`endif
    an_d = '1;
    if (slot_d >= SLOT_W'(GAP)) an_d[dig_d] = 1'b0;
  end

  // Scan counters and registered pin outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      slot_q <= '0;
      dig_q  <= '0;
      seg_q  <= 8'hFF;
      an_q   <= '1;
    end else begin
      slot_q <= slot_d;
      dig_q  <= dig_d;
      seg_q  <= seg_d;
      an_q   <= an_d;
    end
  end

  assign seg  = seg_q;
  assign an   = an_q;
  assign busy = conv_busy || pend_a_q || pend_b_q;

endmodule
